// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage access unit: FSM states,
// byte-enable constants and the bus timeout limit.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD       = 4'hF;
  localparam int         TIMEOUT_LIMIT = 255;

  function automatic logic [3:0] byte_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: byte loads pick lane addr[1:0] of the bus word and
// sign-extend it; word loads pass the bus word through.
module load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic        byte_i,
  output logic [31:0] data_o
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata_i[8*lane_i +: 8];
    if (byte_i) data_o = {{24{lane_byte[7]}}, lane_byte};
    else        data_o = rdata_i;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus access unit: stalls the pipeline during loads/stores and
// feeds MEM/WB. Define MEM_ACCESS_TIMEOUT_EN to abort accesses never acked.
module mem_access_unit
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_file_out_2_in,
  input  logic [4:0]  register_destination_in,
  input  logic        branch_in,
  input  logic        zero_flag_in,
  input  logic [31:0] branch_target_in,
  input  logic        memory_read_in,
  input  logic        memory_write_in,
  input  logic        memory_read_source_in,
  input  logic        memory_write_source_in,
  input  logic        memory_to_register_in,
  input  logic        reg_write_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall_out,
  output logic        pc_src_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  register_destination_out,
  output logic        reg_write_out,
  output logic        memory_to_register_out,
  output logic        misalign_err_out,
  output logic        timeout_err_out
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mtr_q, mtr_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic        lat_byte_q, lat_byte_d;
  logic        lat_load_q, lat_load_d;
  logic        lat_rw_q, lat_rw_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        is_access, is_store, byte_acc, misaligned;
  logic [31:0] aligned_rdata;

  load_align u_load_align (
    .rdata_i (mem_rdata),
    .lane_i  (mem_addr_q[1:0]),
    .byte_i  (lat_byte_q),
    .data_o  (aligned_rdata)
  );

  // Store wins when both requests are raised; its size flag decides alignment.
  assign is_store   = memory_write_in;
  assign is_access  = memory_read_in | memory_write_in;
  assign byte_acc   = is_store ? memory_write_source_in : memory_read_source_in;
  assign misaligned = is_access & ~byte_acc & (alu_result_in[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mtr_d        = mtr_q;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    lat_byte_d   = lat_byte_q;
    lat_load_d   = lat_load_q;
    lat_rw_d     = lat_rw_q;
    stall_out    = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        alu_result_d = alu_result_in;
        rd_d         = register_destination_in;
        mtr_d        = memory_to_register_in;
        read_data_d  = 32'h0;
        reg_write_d  = 1'b0;
        if (!is_access) begin
          reg_write_d = reg_write_in;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          stall_out   = 1'b1;
          state_d     = ST_ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = alu_result_in;
          mem_be_d    = byte_acc ? byte_be(alu_result_in[1:0]) : BE_WORD;
          mem_wdata_d = !is_store ? 32'h0 :
                        byte_acc  ? {4{reg_file_out_2_in[7:0]}} : reg_file_out_2_in;
          lat_byte_d  = byte_acc;
          lat_load_d  = ~is_store;
          lat_rw_d    = reg_write_in;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      ST_ACCESS: begin
        stall_out = 1'b1;
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          state_d     = ST_DONE;
          read_data_d = lat_load_q ? aligned_rdata : 32'h0;
          reg_write_d = lat_rw_q;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_LIMIT - 1)) begin
          mem_req_d   = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_DONE;
          read_data_d = 32'h0;
          reg_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_DONE: begin
        // Results were shown for one cycle; don't write them back twice.
        state_d     = ST_IDLE;
        reg_write_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'h0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      rd_q         <= 5'h0;
      reg_write_q  <= 1'b0;
      mtr_q        <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      lat_byte_q   <= 1'b0;
      lat_load_q   <= 1'b0;
      lat_rw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mtr_q        <= mtr_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
      lat_byte_q   <= lat_byte_d;
      lat_load_q   <= lat_load_d;
      lat_rw_q     <= lat_rw_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign mem_req                  = mem_req_q;
  assign mem_we                   = mem_we_q;
  assign mem_addr                 = mem_addr_q;
  assign mem_wdata                = mem_wdata_q;
  assign mem_be                   = mem_be_q;
  assign pc_src_out               = branch_in & zero_flag_in;
  assign branch_target_out        = branch_target_in;
  assign read_data_out            = read_data_q;
  assign alu_result_out           = alu_result_q;
  assign register_destination_out = rd_q;
  // A stalled cycle is a bubble for writeback.
  assign reg_write_out            = reg_write_q & ~stall_out;
  assign memory_to_register_out   = mtr_q;
  assign misalign_err_out         = misalign_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
  assign timeout_err_out          = timeout_q;
`else
  assign timeout_err_out          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of MEM/WB results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, reg_file_out_2_in, branch_target_in, mem_rdata;
  logic [4:0]  register_destination_in;
  logic        branch_in, zero_flag_in, memory_read_in, memory_write_in;
  logic        memory_read_source_in, memory_write_source_in;
  logic        memory_to_register_in, reg_write_in, mem_ack;
  logic        mem_req, mem_we, stall_out, pc_src_out;
  logic [31:0] mem_addr, mem_wdata, branch_target_out, read_data_out, alu_result_out;
  logic [3:0]  mem_be;
  logic [4:0]  register_destination_out;
  logic        reg_write_out, memory_to_register_out, misalign_err_out, timeout_err_out;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .reg_file_out_2_in(reg_file_out_2_in),
    .register_destination_in(register_destination_in),
    .branch_in(branch_in), .zero_flag_in(zero_flag_in), .branch_target_in(branch_target_in),
    .memory_read_in(memory_read_in), .memory_write_in(memory_write_in),
    .memory_read_source_in(memory_read_source_in), .memory_write_source_in(memory_write_source_in),
    .memory_to_register_in(memory_to_register_in), .reg_write_in(reg_write_in),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .stall_out(stall_out), .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .register_destination_out(register_destination_out),
    .reg_write_out(reg_write_out), .memory_to_register_out(memory_to_register_out),
    .misalign_err_out(misalign_err_out), .timeout_err_out(timeout_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_inputs();
    alu_result_in = 32'h0; reg_file_out_2_in = 32'h0; register_destination_in = 5'd0;
    memory_read_in = 1'b0; memory_write_in = 1'b0;
    memory_read_source_in = 1'b0; memory_write_source_in = 1'b0;
    memory_to_register_in = 1'b0; reg_write_in = 1'b0;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rdata"}, read_data_out, e.rdata);
    chk({tag, "_alu"}, alu_result_out, e.alu);
    chk({tag, "_rd"}, 32'(register_destination_out), 32'(e.rd));
    chk({tag, "_rw"}, 32'(reg_write_out), 32'(e.rw));
    chk({tag, "_mtr"}, 32'(memory_to_register_out), 32'(e.mtr));
  endtask

  task automatic alu_op(input string tag, input logic [31:0] alu, input logic [4:0] rd,
                        input logic rw, input logic mtr);
    nop_inputs();
    alu_result_in = alu; register_destination_in = rd;
    reg_write_in = rw; memory_to_register_in = mtr;
    sb.push_back('{rdata: 32'h0, alu: alu, rd: rd, rw: rw, mtr: mtr});
    #1;
    chk({tag, "_nostall"}, 32'(stall_out), 32'd0);
    tick();
    check_result(tag);
  endtask

  task automatic mem_op(input string tag, input logic rd_i, input logic wr_i,
                        input logic rsrc, input logic wsrc,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rdest, input logic rw,
                        input int ack_dly, input logic [31:0] rdata, input int exp_stall);
    logic        byt;
    logic [3:0]  be_e;
    logic [31:0] wd_e, rd_e;
    logic [7:0]  lane;
    int          stall_cnt;
    byt  = wr_i ? wsrc : rsrc;
    be_e = byt ? (4'b0001 << addr[1:0]) : 4'hF;
    wd_e = byt ? {4{sdata[7:0]}} : sdata;
    lane = 8'(rdata >> (8 * addr[1:0]));
    rd_e = wr_i ? 32'h0 : (byt ? {{24{lane[7]}}, lane} : rdata);
    nop_inputs();
    memory_read_in = rd_i; memory_write_in = wr_i;
    memory_read_source_in = rsrc; memory_write_source_in = wsrc;
    alu_result_in = addr; reg_file_out_2_in = sdata; register_destination_in = rdest;
    reg_write_in = rw; memory_to_register_in = rd_i & ~wr_i;
    sb.push_back('{rdata: rd_e, alu: addr, rd: rdest, rw: rw, mtr: rd_i & ~wr_i});
    #1;
    chk({tag, "_stall0"}, 32'(stall_out), 32'd1);
    chk({tag, "_bubble"}, 32'(reg_write_out), 32'd0);
    stall_cnt = stall_out ? 1 : 0;
    tick();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_be"}, 32'(mem_be), 32'(be_e));
    chk({tag, "_we"}, 32'(mem_we), 32'(wr_i));
    if (wr_i) chk({tag, "_wdata"}, mem_wdata, wd_e);
    for (int k = 1; k <= ack_dly; k++) begin
      chk({tag, "_hold"}, mem_addr, addr);
      if (stall_out) stall_cnt++;
      if (k == ack_dly) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
    end
    chk({tag, "_stallcnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, "_done_nostall"}, 32'(stall_out), 32'd0);
    chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
    check_result(tag);
    nop_inputs();
    tick();
    chk({tag, "_wb_once"}, 32'(reg_write_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    branch_in = 1'b0; zero_flag_in = 1'b0; branch_target_in = 32'h0;
    nop_inputs();
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_rdata", read_data_out, 32'h0);
    chk("rst_misalign", 32'(misalign_err_out), 32'd0);
    chk("rst_timeout", 32'(timeout_err_out), 32'd0);
    rst = 1'b0;

    branch_in = 1'b1; zero_flag_in = 1'b1; branch_target_in = 32'h0000_0400;
    #1;
    chk("pcsrc_taken", 32'(pc_src_out), 32'd1);
    chk("btarget", branch_target_out, 32'h0000_0400);
    zero_flag_in = 1'b0;
    #1;
    chk("pcsrc_not_taken", 32'(pc_src_out), 32'd0);
    branch_in = 1'b0;
    tick();

    alu_op("alu1", 32'h1234_5678, 5'd7, 1'b1, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    alu_op("ack_idle", 32'h0000_00AA, 5'd9, 1'b1, 1'b0);
    chk("ack_idle_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0; mem_rdata = 32'h0;

    mem_op("lw10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 3, 32'hDEAD_BEEF, 4);
    mem_op("sb13", 1'b0, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0000_00A5, 5'd0, 1'b0, 1, 32'h0, 2);
    mem_op("lb21", 1'b1, 1'b0, 1'b1, 1'b0, 32'h21, 32'h0, 5'd4, 1'b1, 2, 32'h0000_8000, 3);
    mem_op("sw40", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFE_F00D, 5'd0, 1'b0, 1, 32'h0, 2);
    mem_op("rdwr44", 1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1122_3344, 5'd5, 1'b0, 2, 32'h5555_5555, 3);

    nop_inputs();
    memory_read_in = 1'b1; alu_result_in = 32'h22; register_destination_in = 5'd6;
    reg_write_in = 1'b1; memory_to_register_in = 1'b1;
    #1;
    chk("mis_nostall", 32'(stall_out), 32'd0);
    tick();
    chk("mis_err", 32'(misalign_err_out), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_rw", 32'(reg_write_out), 32'd0);
    nop_inputs();
    tick();
    chk("mis_pulse_end", 32'(misalign_err_out), 32'd0);
    chk("mis_req2", 32'(mem_req), 32'd0);

    memory_read_in = 1'b1; alu_result_in = 32'h80; reg_write_in = 1'b1;
    tick();
    chk("mrst_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    nop_inputs();
    tick();
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_stall", 32'(stall_out), 32'd0);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_rdata", read_data_out, 32'h0);
    chk("late_ack_stall", 32'(stall_out), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int seen;
      seen = -1;
      nop_inputs();
      memory_read_in = 1'b1; alu_result_in = 32'h100; reg_write_in = 1'b1;
      tick();
      for (int i = 1; i <= 300; i++) begin
        tick();
        if (timeout_err_out) begin
          seen = i;
          break;
        end
      end
      chk("tmo_cycle", 32'(seen), 32'd255);
      chk("tmo_req", 32'(mem_req), 32'd0);
      chk("tmo_rw", 32'(reg_write_out), 32'd0);
      nop_inputs();
      tick();
      chk("tmo_pulse_end", 32'(timeout_err_out), 32'd0);
    end
`else
    nop_inputs();
    memory_read_in = 1'b1; alu_result_in = 32'h100;
    repeat (20) tick();
    chk("no_tmo_req", 32'(mem_req), 32'd1);
    chk("no_tmo_err", 32'(timeout_err_out), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  reset.
REQ-002 alu_result_in  input  32  memory address or ALU result from EX/MEM.
REQ-003 reg_file_out_2_in  input  32  store data.
REQ-004 register_destination_in  input  5  writeback register index.
REQ-005 branch_in, zero_flag_in  input  1 each  branch request and ALU zero flag.
REQ-006 branch_target_in  input  32  branch target address.
REQ-007 memory_read_in, memory_write_in  input  1 each  load and store request.
REQ-008 memory_read_source_in, memory_write_source_in  input  1 each  byte access when 1, word access when 0.
REQ-009 memory_to_register_in, reg_write_in  input  1 each  writeback controls.
REQ-010 mem_rdata  input  32  and  mem_ack  input  1  memory bus read data and completion.
REQ-011 mem_req, mem_we  output  1 each  and  mem_addr, mem_wdata  output  32  and  mem_be  output  4  memory bus request.
REQ-012 stall_out  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-013 pc_src_out  output  1  and  branch_target_out  output  32  branch redirect.
REQ-014 read_data_out, alu_result_out  output  32  and  register_destination_out  output  5  MEM/WB payload.
REQ-015 reg_write_out, memory_to_register_out  output  1 each  MEM/WB controls.
REQ-016 misalign_err_out, timeout_err_out  output  1 each  one-cycle error pulses.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE with no load or store, MEM/WB outputs SHALL register the inputs at the next edge, giving 1-cycle latency with no stall; read_data_out is 0.
REQ-019 In IDLE with memory_read_in or memory_write_in, stall_out SHALL be 1 combinationally, and at the next edge state becomes ACCESS with mem_req=1 and address, data, be and we registered.
REQ-020 In ACCESS, stall_out=1 and the request SHALL be held stable until mem_ack=1; on ack, mem_rdata is captured, mem_req drops at that edge and state becomes DONE.
REQ-021 In DONE, stall_out=0 and MEM/WB outputs SHALL be loaded with the captured access results; the next state is IDLE.
REQ-022 While stall_out=1, reg_write_out SHALL be 0 (bubble).
REQ-023 Word stores SHALL drive mem_be=4'hF and mem_wdata=store data; byte stores SHALL drive mem_be=1<<addr[1:0] and mem_wdata={4{data[7:0]}}.
REQ-024 Byte loads SHALL select lane addr[1:0] of mem_rdata and sign-extend it to 32 bits.
REQ-025 A word access with addr[1:0]!=0 SHALL issue no bus request; misalign_err_out pulses for 1 cycle, reg_write_out is 0 and there is no stall.
REQ-026 If memory_read_in and memory_write_in are both 1, the store SHALL take priority.
REQ-027 mem_ack SHALL be ignored outside ACCESS.
REQ-028 pc_src_out = branch_in & zero_flag_in combinationally, and branch_target_out = branch_target_in.

Reset
REQ-029 When rst=1 at a clock edge, the state SHALL become IDLE and every output register SHALL become 0; a mid-access reset drops mem_req at that edge, and a late mem_ack is ignored.

Configuration
REQ-030 With MEM_ACCESS_TIMEOUT_EN defined, an 8-bit counter SHALL run in ACCESS; 255 cycles without ack aborts the access (mem_req=0, timeout_err_out pulses for 1 cycle, state DONE with reg_write_out=0). Without the macro, ACCESS waits indefinitely and timeout_err_out is tied to 0.

Structure
REQ-031 Package mips_mem_pkg SHALL hold the FSM state enum, the BE_WORD constant, and TIMEOUT_LIMIT=255.
REQ-032 Sub-module load_align SHALL implement byte lane select and sign-extension.

Verification
REQ-033 Load word at addr 0x10, ack after 3 cycles, rdata 0xDEADBEEF -> stall for 4 cycles, then read_data_out=0xDEADBEEF, reg_write_out=1.
REQ-034 Byte store at addr 0x13 with data 0x000000A5 -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-035 Byte load at addr 0x21 with rdata 0x00008000 -> read_data_out=0xFFFFFF80.
REQ-036 Word load at addr 0x22 -> misalign_err_out=1 for 1 cycle, mem_req stays 0, reg_write_out=0.
REQ-037 rst=1 in ACCESS followed by ack -> mem_req=0, state IDLE; with MEM_ACCESS_TIMEOUT_EN and no ack -> timeout_err_out pulses at cycle 255.
